// File: rtl/event_sched_pkg.sv
// Shared types and helpers for the event handoff scheduler.
package event_sched_pkg;

    localparam int unsigned XFER_CNT_W = 16;
    localparam int unsigned MAX_REQ    = 16;
    localparam int unsigned IDX_W      = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        DELAY    = 3'd2,
        NOTIFY   = 3'd3,
        WAIT_ACK = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic [MAX_REQ-1:0] onehot;
        logic [IDX_W-1:0]   idx;
        logic               valid;
    } rr_pick_t;

    // First set request at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int unsigned        n);
        rr_pick_t    r;
        int unsigned i;
        r = '0;
        for (int unsigned k = 0; k < n; k++) begin
            i = (32'(ptr) + k) % n;
            if (!r.valid && req[i]) begin
                r.valid     = 1'b1;
                r.idx       = IDX_W'(i);
                r.onehot[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker with a registered rotating priority pointer.
module rr_arbiter
    import event_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    input  logic [IDX_W-1:0] adv_idx,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    logic [IDX_W-1:0]   ptr_q;
    logic [MAX_REQ-1:0] req_ext;
    rr_pick_t           pick;
    logic               unused_onehot;

    always_comb begin
        req_ext             = '0;
        req_ext[N_REQ-1:0]  = req;
        pick                = rr_pick(req_ext, ptr_q, N_REQ);
        win_idx             = pick.idx;
        win_valid           = pick.valid;
        unused_onehot       = ^pick.onehot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            if (adv_idx == IDX_W'(N_REQ - 1))
                ptr_q <= '0;
            else
                ptr_q <= adv_idx + 4'd1;
        end
    end

endmodule

// File: rtl/event_handoff_sched.sv
// Serialises requester writes into one shared value register and sequences
// the update -> delayed notify -> acknowledge handshake to a single consumer.
module event_handoff_sched
    import event_sched_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NOTIFY_DLY  = 1,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        grant,
    output logic [DATA_W-1:0]       value,
    output logic                    update,
    output logic                    notify,
    input  logic                    ack,
    output logic                    busy,
    output logic                    timeout,
    output logic [XFER_CNT_W-1:0]   xfer_cnt
);

    sched_state_e          state_q;
    logic [IDX_W-1:0]      win_q;
    logic [3:0]            dly_q;
    logic [15:0]           to_q;
    logic [XFER_CNT_W-1:0] xfer_q;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_valid;
    logic [DATA_W-1:0]     sel_data;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .advance   (state_q == WRITE),
        .adv_idx   (win_q),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_q == IDX_W'(i))
                sel_data = wdata[i*DATA_W +: DATA_W];
        end
    end

    assign busy     = (state_q != IDLE);
    assign xfer_cnt = xfer_q;

    // Outputs are registered: each pulse is visible in the cycle after its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            dly_q   <= '0;
            to_q    <= '0;
            xfer_q  <= '0;
            value   <= '0;
            grant   <= '0;
            update  <= 1'b0;
            notify  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            grant  <= '0;
            update <= 1'b0;
            notify <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        win_q   <= win_idx;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    value  <= sel_data;
                    grant  <= N_REQ'(1) << win_q;
                    update <= 1'b1;
                    if (NOTIFY_DLY == 0) begin
                        state_q <= NOTIFY;
                    end else begin
                        dly_q   <= 4'(NOTIFY_DLY - 1);
                        state_q <= DELAY;
                    end
                end
                DELAY: begin
                    if (dly_q == 4'd0)
                        state_q <= NOTIFY;
                    else
                        dly_q <= dly_q - 4'd1;
                end
                NOTIFY: begin
                    notify  <= 1'b1;
                    to_q    <= '0;
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack) begin
                        xfer_q  <= xfer_q + 16'd1;
                        state_q <= IDLE;
                    end else if (to_q == 16'(ACK_TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        to_q <= to_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_event_handoff_sched.sv
// Directed bench for event_handoff_sched using three parameterisations.
module tb_event_handoff_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned nq;

    // Instance A: NOTIFY_DLY=1, ACK_TIMEOUT=8
    logic         a_rst_n, a_ack, a_update, a_notify, a_busy, a_to;
    logic [3:0]   a_req, a_grant;
    logic [127:0] a_wdata;
    logic [31:0]  a_value;
    logic [15:0]  a_cnt;
    // Instance B: NOTIFY_DLY=0
    logic         b_rst_n, b_ack, b_update, b_notify, b_busy, b_to;
    logic [3:0]   b_req, b_grant;
    logic [127:0] b_wdata;
    logic [31:0]  b_value;
    logic [15:0]  b_cnt;
    // Instance C: NOTIFY_DLY=5
    logic         c_rst_n, c_ack, c_update, c_notify, c_busy, c_to;
    logic [3:0]   c_req, c_grant;
    logic [127:0] c_wdata;
    logic [31:0]  c_value;
    logic [15:0]  c_cnt;

    event_handoff_sched #(.N_REQ(4), .DATA_W(32), .NOTIFY_DLY(1), .ACK_TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .req(a_req), .wdata(a_wdata), .grant(a_grant),
        .value(a_value), .update(a_update), .notify(a_notify), .ack(a_ack),
        .busy(a_busy), .timeout(a_to), .xfer_cnt(a_cnt));

    event_handoff_sched #(.N_REQ(4), .DATA_W(32), .NOTIFY_DLY(0), .ACK_TIMEOUT(64)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .req(b_req), .wdata(b_wdata), .grant(b_grant),
        .value(b_value), .update(b_update), .notify(b_notify), .ack(b_ack),
        .busy(b_busy), .timeout(b_to), .xfer_cnt(b_cnt));

    event_handoff_sched #(.N_REQ(4), .DATA_W(32), .NOTIFY_DLY(5), .ACK_TIMEOUT(64)) dut_c (
        .clk(clk), .rst_n(c_rst_n), .req(c_req), .wdata(c_wdata), .grant(c_grant),
        .value(c_value), .update(c_update), .notify(c_notify), .ack(c_ack),
        .busy(c_busy), .timeout(c_to), .xfer_cnt(c_cnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        a_rst_n = 1'b0; a_req = '0; a_wdata = '0; a_ack = 1'b0;
        b_rst_n = 1'b0; b_req = '0; b_wdata = '0; b_ack = 1'b0;
        c_rst_n = 1'b0; c_req = '0; c_wdata = '0; c_ack = 1'b0;
        tick(2);
        chk("rst_value",  a_value, 32'h0);
        chk("rst_grant",  32'(a_grant), 32'h0);
        chk("rst_update", 32'(a_update), 32'h0);
        chk("rst_notify", 32'(a_notify), 32'h0);
        chk("rst_busy",   32'(a_busy), 32'h0);
        chk("rst_timeout", 32'(a_to), 32'h0);
        chk("rst_cnt",    32'(a_cnt), 32'h0);
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

        // Single requester
        a_req = 4'b0100; a_wdata[95:64] = 32'h1;
        tick(1);
        chk("single_busy",  32'(a_busy), 32'h1);
        chk("single_nogrant", 32'(a_grant), 32'h0);
        tick(1);
        chk("single_grant", 32'(a_grant), 32'h4);
        chk("single_update", 32'(a_update), 32'h1);
        chk("single_value", a_value, 32'h1);
        a_req = '0;
        tick(1);
        chk("single_update_off", 32'(a_update), 32'h0);
        chk("single_notify_early", 32'(a_notify), 32'h0);
        tick(1);
        chk("single_notify", 32'(a_notify), 32'h1);
        a_ack = 1'b1;
        tick(1);
        chk("single_cnt", 32'(a_cnt), 32'h1);
        chk("single_idle", 32'(a_busy), 32'h0);
        a_ack = 1'b0;

        // Fairness from a fresh pointer
        a_rst_n = 1'b0;
        #1;
        chk("rst_ptr_a", 32'(dut_a.u_arb.ptr_q), 32'h0);
        chk("rst_value_a", a_value, 32'h0);
        tick(1);
        a_rst_n = 1'b1;
        a_req = 4'b1111;
        a_wdata = {32'd4, 32'd3, 32'd2, 32'd1};
        a_ack = 1'b1;
        tick(1);
        for (int g = 0; g < 5; g++) begin
            tick(1);
            chk($sformatf("fair_grant%0d", g), 32'(a_grant), 32'(1) << (g % 4));
            chk($sformatf("fair_value%0d", g), a_value, 32'((g % 4) + 1));
            if (g < 4) tick(4);
        end
        a_req = '0;
        tick(3);
        chk("fair_cnt", 32'(a_cnt), 32'd5);
        chk("fair_idle", 32'(a_busy), 32'h0);

        // Ack timeout, then a later request is still served
        a_ack = 1'b0;
        a_req = 4'b0010; a_wdata[63:32] = 32'hAB;
        tick(2);
        chk("to_grant", 32'(a_grant), 32'h2);
        chk("to_value", a_value, 32'hAB);
        a_req = '0;
        tick(2);
        tick(7);
        chk("to_not_yet", 32'(a_to), 32'h0);
        chk("to_busy", 32'(a_busy), 32'h1);
        tick(1);
        chk("to_flag", 32'(a_to), 32'h1);
        chk("to_idle", 32'(a_busy), 32'h0);
        chk("to_cnt_kept", 32'(a_cnt), 32'd5);
        a_req = 4'b1000; a_wdata[127:96] = 32'h55; a_ack = 1'b1;
        tick(2);
        chk("after_to_grant", 32'(a_grant), 32'h8);
        chk("after_to_value", a_value, 32'h55);
        chk("to_sticky", 32'(a_to), 32'h1);
        a_req = '0;
        tick(3);
        chk("after_to_cnt", 32'(a_cnt), 32'd6);

        // Transfer counter wrap
        force dut_a.xfer_q = 16'hFFFF;
        tick(1);
        release dut_a.xfer_q;
        chk("wrap_preload", 32'(a_cnt), 32'hFFFF);
        a_req = 4'b0001; a_wdata[31:0] = 32'h77;
        tick(2);
        chk("wrap_grant", 32'(a_grant), 32'h1);
        a_req = '0;
        tick(3);
        chk("wrap_cnt", 32'(a_cnt), 32'h0);
        chk("wrap_value", a_value, 32'h77);
        chk("wrap_idle", 32'(a_busy), 32'h0);
        chk("wrap_timeout", 32'(a_to), 32'h1);
        a_ack = 1'b0;

        // NOTIFY_DLY=0: ack during NOTIFY is ignored
        b_req = 4'b0001; b_wdata[31:0] = 32'h11;
        tick(2);
        chk("d0_update", 32'(b_update), 32'h1);
        chk("d0_grant", 32'(b_grant), 32'h1);
        b_req = '0;
        b_ack = 1'b1;
        tick(1);
        chk("d0_notify", 32'(b_notify), 32'h1);
        b_ack = 1'b0;
        tick(2);
        chk("d0_wait_busy", 32'(b_busy), 32'h1);
        chk("d0_wait_cnt", 32'(b_cnt), 32'h0);
        chk("d0_notify_once", 32'(b_notify), 32'h0);
        b_ack = 1'b1;
        tick(1);
        chk("d0_cnt", 32'(b_cnt), 32'h1);
        chk("d0_idle", 32'(b_busy), 32'h0);
        b_ack = 1'b0;

        // Reset during DELAY discards the handoff
        c_req = 4'b0100; c_wdata[95:64] = 32'h99;
        tick(2);
        chk("dly5_update", 32'(c_update), 32'h1);
        chk("dly5_value", c_value, 32'h99);
        c_req = '0;
        nq = 0;
        for (int t = 0; t < 2; t++) begin
            tick(1);
            if (c_notify) nq++;
        end
        c_rst_n = 1'b0;
        #1;
        chk("dly5_rst_value", c_value, 32'h0);
        chk("dly5_rst_busy", 32'(c_busy), 32'h0);
        chk("dly5_rst_ptr", 32'(dut_c.u_arb.ptr_q), 32'h0);
        for (int t = 0; t < 2; t++) begin
            tick(1);
            if (c_notify) nq++;
        end
        c_rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick(1);
            if (c_notify) nq++;
        end
        chk("dly5_no_notify", nq, 32'h0);
        chk("dly5_cnt", 32'(c_cnt), 32'h0);
        chk("dly5_idle", 32'(c_busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
